// File: rtl/ecc_sync_fifo.sv
// ecc_sync_fifo: parametrised single-clock FIFO with Hamming SEC protection.
//
// Each word is Hamming-encoded on write and decoded/corrected on read. The read
// port is registered and has a valid strobe. A read can peek at the head word or
// pop it. The block also reports occupancy, sticky overflow/underflow flags and a
// saturating count of reads that returned a non-zero syndrome.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active high
//   wr_en        write request, dropped while full
//   wr_data      write data (WIDTH)
//   rd_en        read request, ignored while empty
//   rd_peek      with rd_en: return the head word without popping it
//   err_cnt_clr  clear err_cnt (wins over a same-cycle increment)
//   rd_valid     rd_data/rd_err_idx hold a fresh read this cycle
//   rd_data      corrected read data (WIDTH), holds when rd_valid=0
//   rd_err_idx   syndrome (ERRDATA); 0 = clean, else codeword bit idx-1 was bad
//   count        occupancy 0..DEPTH (ADDR+1)
//   fifo_status  0 empty, 1 <1/4, 2 <1/2, 3 <3/4, 4 <full, 5 full
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
//   err_cnt      saturating count of errored reads (CNTW)
//
// Optional build macro ECC_ERR_INJECT_EN adds inj_en/inj_pos. On an accepted
// write with inj_en=1, codeword bit inj_pos-1 is inverted before storage. When
// inj_pos is 0 or greater than the codeword length, nothing is flipped.
module ecc_sync_fifo #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned ADDR    = 10,
   parameter int unsigned ERRDATA = 6,
   parameter int unsigned CNTW    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [WIDTH-1:0]   wr_data,
   input  logic               rd_en,
   input  logic               rd_peek,
   input  logic               err_cnt_clr,
`ifdef ECC_ERR_INJECT_EN
   input  logic               inj_en,
   input  logic [ERRDATA-1:0] inj_pos,
`endif
   output logic               rd_valid,
   output logic [WIDTH-1:0]   rd_data,
   output logic [ERRDATA-1:0] rd_err_idx,
   output logic [ADDR:0]      count,
   output logic [2:0]         fifo_status,
   output logic               overflow,
   output logic               underflow,
   output logic [CNTW-1:0]    err_cnt
);

   localparam int unsigned N     = WIDTH + ERRDATA;
   localparam int unsigned DEPTH = 1 << ADDR;
   localparam int unsigned Q1    = DEPTH / 4;
   localparam int unsigned Q2    = DEPTH / 2;
   localparam int unsigned Q3    = (3 * DEPTH) / 4;

   // Syndrome: XOR of the 1-based positions of all set codeword bits.
   function automatic logic [ERRDATA-1:0] syndrome(input logic [N-1:0] cw);
      logic [ERRDATA-1:0] s;
      s = '0;
      for (int unsigned p = 1; p <= N; p++) begin
         if (cw[p-1]) s = s ^ ERRDATA'(p);
      end
      return s;
   endfunction

   // Data fills the non-power-of-two positions LSB-first. The parity bits are then
   // set to the data-only syndrome, which makes the full-word syndrome zero.
   function automatic logic [N-1:0] encode(input logic [WIDTH-1:0] d);
      logic [N-1:0]       cw;
      logic [ERRDATA-1:0] s;
      int unsigned        j;
      cw = '0;
      j  = 0;
      for (int unsigned p = 1; p <= N; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (j < WIDTH) cw[p-1] = d[j];
            j++;
         end
      end
      s = syndrome(cw);
      for (int unsigned k = 0; k < ERRDATA; k++) begin
         if ((1 << k) <= N) cw[(1 << k) - 1] = s[k];
      end
      return cw;
   endfunction

   function automatic logic [WIDTH-1:0] extract(input logic [N-1:0] cw);
      logic [WIDTH-1:0] d;
      int unsigned      j;
      d = '0;
      j = 0;
      for (int unsigned p = 1; p <= N; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (j < WIDTH) d[j] = cw[p-1];
            j++;
         end
      end
      return d;
   endfunction

   logic [N-1:0]       mem [DEPTH];
   logic [ADDR-1:0]    wr_ptr;
   logic [ADDR-1:0]    rd_ptr;
   logic               wr_acc;
   logic               rd_acc;
   logic               pop;
   logic [N-1:0]       wr_cw;
   logic [N-1:0]       rd_cw;
   logic [N-1:0]       fix_cw;
   logic [ERRDATA-1:0] rd_syn;
   logic [WIDTH-1:0]   rd_dec;
   logic [ADDR:0]      count_nxt;
   logic [2:0]         status_nxt;

   // Accept decisions use the occupancy before this cycle's operations. A pop in
   // the same cycle therefore does not make room for a write while full.
   always_comb begin
      wr_acc = wr_en && (count != (ADDR+1)'(DEPTH));
      rd_acc = rd_en && (count != '0);
      pop    = rd_acc && !rd_peek;
   end

   // Write-side encode, with an optional single-bit corruption for self-test.
   always_comb begin
      wr_cw = encode(wr_data);
`ifdef ECC_ERR_INJECT_EN
      for (int unsigned p = 1; p <= N; p++) begin
         if (inj_en && (32'(inj_pos) == p)) wr_cw[p-1] = ~wr_cw[p-1];
      end
`endif
   end

   // Read-side decode of the head word. A syndrome of 0 or one beyond N flips nothing.
   always_comb begin
      rd_cw  = mem[rd_ptr];
      rd_syn = syndrome(rd_cw);
      fix_cw = rd_cw;
      for (int unsigned p = 1; p <= N; p++) begin
         if (32'(rd_syn) == p) fix_cw[p-1] = ~fix_cw[p-1];
      end
      rd_dec = extract(fix_cw);
   end

   // Next occupancy and status band.
   always_comb begin
      count_nxt = count;
      if (wr_acc && !pop)      count_nxt = count + (ADDR+1)'(1);
      else if (!wr_acc && pop) count_nxt = count - (ADDR+1)'(1);

      if (count_nxt == '0)              status_nxt = 3'd0;
      else if (32'(count_nxt) < Q1)     status_nxt = 3'd1;
      else if (32'(count_nxt) < Q2)     status_nxt = 3'd2;
      else if (32'(count_nxt) < Q3)     status_nxt = 3'd3;
      else if (32'(count_nxt) < DEPTH)  status_nxt = 3'd4;
      else                              status_nxt = 3'd5;
   end

   // Storage array; reset only moves the pointers, so the contents become unreachable.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_cw;
   end

   // Pointers, occupancy, read port and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         fifo_status <= 3'd0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         rd_err_idx  <= '0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + ADDR'(1);
         if (pop)    rd_ptr <= rd_ptr + ADDR'(1);
         count       <= count_nxt;
         fifo_status <= status_nxt;
         rd_valid    <= rd_acc;
         if (rd_acc) begin
            rd_data    <= rd_dec;
            rd_err_idx <= rd_syn;
         end
         if (wr_en && !wr_acc) overflow  <= 1'b1;
         if (rd_en && !rd_acc) underflow <= 1'b1;
      end
   end

   // Error counter counts presented reads with a non-zero syndrome. It saturates at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (err_cnt_clr) begin
         err_cnt <= '0;
      end else if (rd_valid && (rd_err_idx != '0) && (err_cnt != '1)) begin
         err_cnt <= err_cnt + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_ecc_sync_fifo.sv
// Self-checking bench for ecc_sync_fifo. It uses a small DEPTH (16) and a 4-bit
// error counter so the full, wrap and saturation boundaries can all be reached.
module tb_ecc_sync_fifo;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned ADDR    = 4;
   localparam int unsigned ERRDATA = 6;
   localparam int unsigned CNTW    = 4;
   localparam int unsigned DEPTH   = 16;
   localparam int unsigned N       = WIDTH + ERRDATA;

   logic               clk = 1'b0;
   logic               rst;
   logic               wr_en;
   logic [WIDTH-1:0]   wr_data;
   logic               rd_en;
   logic               rd_peek;
   logic               err_cnt_clr;
   logic               inj_en;
   logic [ERRDATA-1:0] inj_pos;
   logic               rd_valid;
   logic [WIDTH-1:0]   rd_data;
   logic [ERRDATA-1:0] rd_err_idx;
   logic [ADDR:0]      count;
   logic [2:0]         fifo_status;
   logic               overflow;
   logic               underflow;
   logic [CNTW-1:0]    err_cnt;

   always #5 clk = ~clk;

   ecc_sync_fifo #(.WIDTH(WIDTH), .ADDR(ADDR), .ERRDATA(ERRDATA), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_peek(rd_peek), .err_cnt_clr(err_cnt_clr),
`ifdef ECC_ERR_INJECT_EN
      .inj_en(inj_en), .inj_pos(inj_pos),
`endif
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_err_idx(rd_err_idx), .count(count),
      .fifo_status(fifo_status), .overflow(overflow), .underflow(underflow),
      .err_cnt(err_cnt)
   );

   int checks = 0;
   int passes = 0;

   // Reference model: a queue of words, each with the syndrome it will read back with.
   typedef struct {
      logic [31:0] d;
      logic [5:0]  syn;
   } ent_t;
   ent_t        q[$];
   logic        m_valid, m_ovf, m_udf;
   logic [31:0] m_data;
   logic [5:0]  m_idx;
   int          m_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int status_of(input int c);
      if (c == 0) return 0;
      if (c < int'(DEPTH / 4)) return 1;
      if (c < int'(DEPTH / 2)) return 2;
      if (c < int'(3 * DEPTH / 4)) return 3;
      if (c < int'(DEPTH)) return 4;
      return 5;
   endfunction

   task automatic compare_all();
      check("rd_valid", 64'(rd_valid), 64'(m_valid));
      check("rd_data", 64'(rd_data), 64'(m_data));
      check("rd_err_idx", 64'(rd_err_idx), 64'(m_idx));
      check("count", 64'(count), 64'(q.size()));
      check("fifo_status", 64'(fifo_status), 64'(status_of(q.size())));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("underflow", 64'(underflow), 64'(m_udf));
      check("err_cnt", 64'(err_cnt), 64'(m_err));
   endtask

   task automatic do_reset();
      rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; rd_peek = 1'b0;
      err_cnt_clr = 1'b0; inj_en = 1'b0; inj_pos = '0;
      q.delete();
      m_valid = 1'b0; m_data = '0; m_idx = '0; m_ovf = 1'b0; m_udf = 1'b0; m_err = 0;
      @(posedge clk); #1;
      compare_all();
      rst = 1'b0;
   endtask

   // Apply one cycle of stimulus, advance the model and compare all outputs.
   task automatic cyc(input logic w, input logic [31:0] d, input logic r, input logic pk,
                      input logic clr, input logic ie, input logic [5:0] ip);
      logic prev_valid;
      logic [5:0] prev_idx;
      bit full, empty;
      ent_t e;
      wr_en = w; wr_data = d; rd_en = r; rd_peek = pk; err_cnt_clr = clr;
      inj_en = ie; inj_pos = ip;
      prev_valid = m_valid; prev_idx = m_idx;
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      m_valid = 1'b0;
      if (r) begin
         if (empty) m_udf = 1'b1;
         else begin
            m_valid = 1'b1; m_data = q[0].d; m_idx = q[0].syn;
            if (!pk) void'(q.pop_front());
         end
      end
      if (w) begin
         if (full) m_ovf = 1'b1;
         else begin
            e.d = d;
            e.syn = '0;
`ifdef ECC_ERR_INJECT_EN
            if (ie && ip >= 1 && 32'(ip) <= N) e.syn = ip;
`endif
            q.push_back(e);
         end
      end
      if (clr) m_err = 0;
      else if (prev_valid && prev_idx != 0 && m_err < (1 << CNTW) - 1) m_err++;
      @(posedge clk); #1;
      compare_all();
   endtask

   typedef struct {
      logic        w;
      logic [31:0] d;
      logic        r;
      logic        pk;
      logic        ev;
      logic [31:0] ed;
      logic [4:0]  ec;
      logic [2:0]  es;
      logic        eu;
   } vec_t;
   vec_t vecs[9];

   initial begin
      vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,        5'd1, 3'd1, 1'b0};
      vecs[1] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 5'd0, 3'd0, 1'b0};
      vecs[2] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 5'd0, 3'd0, 1'b0};
      vecs[3] = '{1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 5'd1, 3'd1, 1'b0};
      vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 5'd1, 3'd1, 1'b0};
      vecs[5] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 5'd1, 3'd1, 1'b0};
      vecs[6] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 5'd0, 3'd0, 1'b0};
      vecs[7] = '{1'b1, 32'h1,        1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 5'd1, 3'd1, 1'b1};
      vecs[8] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h1,        5'd0, 3'd0, 1'b1};

      // Reset values as fixed constants.
      do_reset();
      check("rst_count", 64'(count), 64'd0);
      check("rst_status", 64'(fifo_status), 64'd0);
      check("rst_valid", 64'(rd_valid), 64'd0);

      // Basic write/pop, peek and empty-pop sequences from the vector table.
      for (int i = 0; i < 9; i++) begin
         cyc(vecs[i].w, vecs[i].d, vecs[i].r, vecs[i].pk, 1'b0, 1'b0, 6'd0);
         check($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(vecs[i].ev));
         check($sformatf("vec%0d_data", i), 64'(rd_data), 64'(vecs[i].ed));
         check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].ec));
         check($sformatf("vec%0d_status", i), 64'(fifo_status), 64'(vecs[i].es));
         check($sformatf("vec%0d_udf", i), 64'(underflow), 64'(vecs[i].eu));
      end

      // Fill, overflow, then drain in order.
      do_reset();
      for (int i = 0; i < int'(DEPTH); i++) cyc(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
      check("full_count", 64'(count), 64'(DEPTH));
      check("full_status", 64'(fifo_status), 64'd5);
      cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_count", 64'(count), 64'(DEPTH));
      for (int i = 0; i < int'(DEPTH); i++) begin
         cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
         check($sformatf("drain%0d", i), 64'(rd_data), 64'(i));
      end
      check("drain_status", 64'(fifo_status), 64'd0);

      // A write while full is dropped even when a pop happens in the same cycle.
      do_reset();
      for (int i = 0; i < int'(DEPTH); i++) cyc(1'b1, 32'(i + 100), 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
      cyc(1'b1, 32'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
      check("fullpop_count", 64'(count), 64'(DEPTH - 1));
      check("fullpop_ovf", 64'(overflow), 64'd1);

      // Reset in mid-operation discards the stored contents.
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
      do_reset();
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
      check("midrst_udf", 64'(underflow), 64'd1);

      // Write and pop every cycle across 3*DEPTH words so both pointers wrap.
      do_reset();
      cyc(1'b1, 32'hC0DE_0000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
      for (int i = 0; i < 3 * int'(DEPTH); i++) begin
         cyc(1'b1, 32'hC0DE_0001 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
         check($sformatf("wrap%0d_count", i), 64'(count), 64'd1);
      end

`ifdef ECC_ERR_INJECT_EN
      // Injected single-bit error is corrected and counted; clear wins over increment.
      do_reset();
      cyc(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 6'd7);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
      check("inj_data", 64'(rd_data), 64'h12345678);
      check("inj_idx", 64'(rd_err_idx), 64'd7);
      cyc(1'b1, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 1'b1, 6'd3);
      check("inj_errcnt", 64'(err_cnt), 64'd1);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
      check("clr_prio", 64'(err_cnt), 64'd0);
      // Saturation: repeated errored peeks.
      cyc(1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 6'd38);
      for (int i = 0; i < 20; i++) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
      check("sat_errcnt", 64'(err_cnt), 64'd15);
`endif

      // Randomised traffic in phases with varying write/read bias.
      do_reset();
      for (int ph = 0; ph < 12; ph++) begin
         int pw;
         int pr;
         pw = int'($urandom_range(90, 10));
         pr = 100 - pw;
         for (int i = 0; i < 200; i++) begin
            logic w, r, pk, clr, ie;
            logic [5:0] ip;
            w   = ($urandom_range(99) < 32'(pw));
            r   = ($urandom_range(99) < 32'(pr));
            pk  = ($urandom_range(3) == 0);
            clr = ($urandom_range(63) == 0);
            ie  = ($urandom_range(1) == 1);
            ip  = 6'($urandom_range(63));
`ifndef ECC_ERR_INJECT_EN
            ie = 1'b0;
`endif
            cyc(w, $urandom, r, pk, clr, ie, ip);
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
